// File: rtl/traffic_pkg.sv
// Shared encodings for the junction phase scheduler: light codes, FSM states,
// approach indices and the round-robin approach picker.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        PED     = 2'd3
    } state_e;

    localparam logic [1:0] AP_M1 = 2'd0;
    localparam logic [1:0] AP_M2 = 2'd1;
    localparam logic [1:0] AP_MT = 2'd2;
    localparam logic [1:0] AP_S  = 2'd3;

    // First requesting approach after cur (wrapping); M1 is the rest phase when idle.
    function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = AP_M1;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable phase down-counter. Moves only on tick; expire flags the tick on
// which a state loaded with N has lasted exactly N ticks.
module tl_phase_timer #(
    parameter int TW      = 8,
    parameter int RST_VAL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expire
);

    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = load_val;
        end else if (tick) begin
            timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= TW'(RST_VAL);
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire = tick && (timer_q == TW'(1));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach junction phase scheduler: round-robin service, queue-scaled green,
// yellow then all-red clearance. Define TRAFFIC_PED_EN to add the pedestrian phase.
//
// state   | meaning
// ALL_RED | clearance; on expiry pick the next approach (or PED)
// GREEN   | approach cur shows green; holds with MIN_GREEN reloads if nobody else waits
// YELLOW  | approach cur shows yellow; expiry pulses phase_done
// PED     | all heads red, pedestrian walk lit (TRAFFIC_PED_EN only)
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 12,
    parameter int EXT_PER_VEH = 1,
    parameter int YELLOW_T    = 2,
    parameter int ALL_RED_T   = 1,
    parameter int TW          = 8
`ifdef TRAFFIC_PED_EN
    ,
    parameter int PED_T       = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [4:0] veh_M1,
    input  logic [4:0] veh_M2,
    input  logic [4:0] veh_MT,
    input  logic [4:0] veh_S,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [1:0] phase_id,
    output logic       phase_done
`ifdef TRAFFIC_PED_EN
    ,
    input  logic       ped_req,
    output logic       ped_walk
`endif
);

    localparam int PW      = 5 + $clog2(EXT_PER_VEH + 1);
    localparam int EXT_MAX = MAX_GREEN - MIN_GREEN;

    state_e           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       phase_id_q, phase_id_d;
    logic             phase_done_q, phase_done_d;
    logic [3:0][2:0]  lights_q, lights_d;

    logic [3:0][4:0]  veh;
    logic [3:0]       req;
    logic [1:0]       winner;
    logic [PW-1:0]    prod;
    logic [TW-1:0]    green_len;
    logic             other_demand;

    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             expire;

`ifdef TRAFFIC_PED_EN
    logic             ped_lat_q, ped_lat_d;
    logic             ped_walk_q, ped_walk_d;
    logic             enter_ped;
`endif

    tl_phase_timer #(
        .TW      (TW),
        .RST_VAL (ALL_RED_T)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire)
    );

    assign veh = {veh_S, veh_MT, veh_M2, veh_M1};

    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++) begin
            req[i] = (veh[i] != 5'd0);
        end
    end

    assign winner       = rr_pick(cur_q, req);
    assign other_demand = |(req & ~(4'b0001 << cur_q));
    assign prod         = PW'(veh[winner]) * PW'(EXT_PER_VEH);

    // Clamp at full product width so large queues cannot wrap below the limit.
    always_comb begin
        if (int'(prod) > EXT_MAX) begin
            green_len = TW'(MAX_GREEN);
        end else begin
            green_len = TW'(MIN_GREEN + int'(prod));
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ALL_RED;
            cur_q        <= AP_S;
            phase_id_q   <= AP_M1;
            phase_done_q <= 1'b0;
            lights_q     <= {4{LT_RED}};
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            phase_id_q   <= phase_id_d;
            phase_done_q <= phase_done_d;
            lights_q     <= lights_d;
        end
    end

    // Next-state and timer-load logic
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        phase_id_d = phase_id_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_q)
            ALL_RED: begin
                if (expire) begin
                    tmr_load = 1'b1;
`ifdef TRAFFIC_PED_EN
                    if (ped_lat_q) begin
                        state_d = PED;
                        tmr_val = TW'(PED_T);
                    end else
`endif
                    begin
                        state_d    = GREEN;
                        cur_d      = winner;
                        phase_id_d = winner;
                        tmr_val    = green_len;
                    end
                end
            end
            GREEN: begin
                if (expire) begin
                    tmr_load = 1'b1;
                    if (other_demand) begin
                        state_d = YELLOW;
                        tmr_val = TW'(YELLOW_T);
                    end else begin
                        tmr_val = TW'(MIN_GREEN);
                    end
                end
            end
            YELLOW: begin
                if (expire) begin
                    state_d  = ALL_RED;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ALL_RED_T);
                end
            end
            default: begin
                if (expire) begin
                    state_d  = ALL_RED;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ALL_RED_T);
                end
            end
        endcase
    end

    // Output decode from the next state so outputs line up with the registered state
    always_comb begin
        lights_d = {4{LT_RED}};
        if (state_d == GREEN) begin
            lights_d[cur_d] = LT_GRN;
        end else if (state_d == YELLOW) begin
            lights_d[cur_d] = LT_YEL;
        end
        phase_done_d = (state_q == YELLOW) && (state_d == ALL_RED);
    end

`ifdef TRAFFIC_PED_EN
    assign enter_ped  = (state_q == ALL_RED) && expire && ped_lat_q;
    // A request in the entry cycle itself is kept for the next clearance.
    assign ped_lat_d  = ped_req || (ped_lat_q && !enter_ped);
    assign ped_walk_d = (state_d == PED);

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_lat_q  <= 1'b0;
            ped_walk_q <= 1'b0;
        end else begin
            ped_lat_q  <= ped_lat_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign ped_walk = ped_walk_q;
`endif

    assign light_M1   = lights_q[AP_M1];
    assign light_M2   = lights_q[AP_M2];
    assign light_MT   = lights_q[AP_MT];
    assign light_S    = lights_q[AP_S];
    assign phase_id   = phase_id_q;
    assign phase_done = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: expected output changes are queued
// with the tick count at which they must appear; a negedge monitor pops and compares.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [4:0] veh_M1 = '0;
    logic [4:0] veh_M2 = '0;
    logic [4:0] veh_MT = '0;
    logic [4:0] veh_S  = '0;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [1:0] phase_id;
    logic       phase_done;
    logic       walk_sig;
`ifdef TRAFFIC_PED_EN
    logic       ped_req = 1'b0;
    logic       ped_walk;
    assign walk_sig = ped_walk;
`else
    assign walk_sig = 1'b0;
`endif

    traffic_phase_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .veh_M1     (veh_M1),
        .veh_M2     (veh_M2),
        .veh_MT     (veh_MT),
        .veh_S      (veh_S),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .phase_id   (phase_id),
        .phase_done (phase_done)
`ifdef TRAFFIC_PED_EN
        ,
        .ped_req    (ped_req),
        .ped_walk   (ped_walk)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] s;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_m;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          tick_cnt = 0;
    logic [15:0] prev_s   = '0;
    logic        rst_last = 1'b1;
    logic [15:0] cur_s;

    assign cur_s = {light_M1, light_M2, light_MT, light_S, phase_id, phase_done, walk_sig};

    // kind: 0 all red, 1 green, 2 yellow on approach ph
    function automatic logic [15:0] mk(int kind, int ph, logic pd, logic w);
        logic [11:0] l;
        l = 12'h924;
        if (kind == 1) l[(3 - ph) * 3 +: 3] = 3'b001;
        if (kind == 2) l[(3 - ph) * 3 +: 3] = 3'b010;
        return {l, 2'(ph), pd, w};
    endfunction

    task automatic push(int t, int kind, int ph, logic pd, logic w);
        exp_t e;
        e.t = t;
        e.s = mk(kind, ph, pd, w);
        exp_q.push_back(e);
    endtask

    task automatic push_done(int t, int ph);
        push(t, 0, ph, 1'b1, 1'b0);
        push(t, 0, ph, 1'b0, 1'b0);
    endtask

    task automatic chk(string nm, logic [15:0] got, logic [15:0] req_v);
        n_tests++;
        if (got !== req_v) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", nm, got, req_v);
        end
    endtask

    task automatic chk_empty(string nm);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events not seen (next t=%0d s=%h)",
                     nm, exp_q.size(), exp_q[0].t, exp_q[0].s);
        end
        exp_q.delete();
    endtask

    task automatic run_ticks(int n);
        repeat (n) begin
            tick = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            tick = 1'b1;
            @(posedge clk);
            #1;
        end
        tick = 1'b0;
    endtask

    task automatic do_reset(string nm, logic tick_v);
        rst  = 1'b1;
        tick = tick_v;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        tick = 1'b0;
        chk(nm, cur_s, mk(0, 0, 1'b0, 1'b0));
    endtask

    task automatic set_veh(int a, int b, int c, int d);
        veh_M1 = 5'(a);
        veh_M2 = 5'(b);
        veh_MT = 5'(c);
        veh_S  = 5'(d);
    endtask

    // Monitor: every output change must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            tick_cnt = 0;
        end else begin
            if (!rst_last && cur_s !== prev_s) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change t=%0d got=%h", tick_cnt, cur_s);
                end else begin
                    e_m = exp_q.pop_front();
                    if (e_m.t != tick_cnt || e_m.s !== cur_s) begin
                        n_fail++;
                        $display("FAIL event got t=%0d s=%h required t=%0d s=%h",
                                 tick_cnt, cur_s, e_m.t, e_m.s);
                    end
                end
            end
            if (!rst_last && prev_s[1]) begin
                n_tests++;
                if (cur_s[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL phase_done_width got=%b required=0", cur_s[1]);
                end
            end
            if (tick) tick_cnt++;
        end
        prev_s   = cur_s;
        rst_last = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // 1: no demand -> M1 green holds forever, no yellow, no phase_done
        set_veh(0, 0, 0, 0);
        do_reset("t1_reset", 1'b0);
        push(1, 1, 0, 1'b0, 1'b0);
        run_ticks(20);
        chk_empty("t1_idle_hold");

        // 2: M2 alone -> 7-tick green then 4-tick holds; M1 arrives later
        set_veh(0, 3, 0, 0);
        do_reset("t2_reset", 1'b0);
        push(1, 1, 1, 1'b0, 1'b0);
        run_ticks(13);
        veh_M1 = 5'd1;
        push(16, 2, 1, 1'b0, 1'b0);
        push_done(18, 1);
        push(19, 1, 0, 1'b0, 1'b0);
        run_ticks(8);
        chk_empty("t2_m2_hold");

        // 3: S green clamped to MAX_GREEN
        set_veh(1, 0, 0, 20);
        do_reset("t3_reset", 1'b0);
        push(1, 1, 0, 1'b0, 1'b0);
        push(6, 2, 0, 1'b0, 1'b0);
        push_done(8, 0);
        push(9, 1, 3, 1'b0, 1'b0);
        push(21, 2, 3, 1'b0, 1'b0);
        push_done(23, 3);
        push(24, 1, 0, 1'b0, 1'b0);
        run_ticks(27);
        chk_empty("t3_clamp");

        // 4: all approaches waiting -> round robin M1, M2, MT, S, M1
        set_veh(1, 1, 1, 1);
        do_reset("t4_reset", 1'b0);
        for (int k = 0; k < 5; k++) begin
            push(1 + 8 * k, 1, k % 4, 1'b0, 1'b0);
            if (k < 4) begin
                push(6 + 8 * k, 2, k % 4, 1'b0, 1'b0);
                push_done(8 + 8 * k, k % 4);
            end
        end
        run_ticks(35);
        chk_empty("t4_round_robin");

        // 5: reset with tick during M2 yellow -> immediate all red, restart at M1
        set_veh(1, 1, 1, 1);
        do_reset("t5_reset", 1'b0);
        push(1, 1, 0, 1'b0, 1'b0);
        push(6, 2, 0, 1'b0, 1'b0);
        push_done(8, 0);
        push(9, 1, 1, 1'b0, 1'b0);
        push(14, 2, 1, 1'b0, 1'b0);
        run_ticks(15);
        chk_empty("t5_pre_reset");
        do_reset("t5_mid_yellow_reset", 1'b1);
        push(1, 1, 0, 1'b0, 1'b0);
        push(6, 2, 0, 1'b0, 1'b0);
        run_ticks(7);
        chk_empty("t5_restart");

`ifdef TRAFFIC_PED_EN
        // 6: pedestrian request during MT green
        set_veh(0, 0, 1, 1);
        do_reset("t6_reset", 1'b0);
        push(1, 1, 2, 1'b0, 1'b0);
        run_ticks(2);
        ped_req = 1'b1;
        @(posedge clk);
        #1;
        ped_req = 1'b0;
        push(6, 2, 2, 1'b0, 1'b0);
        push_done(8, 2);
        push(9, 0, 2, 1'b0, 1'b1);
        push(12, 0, 2, 1'b0, 1'b0);
        push(13, 1, 3, 1'b0, 1'b0);
        run_ticks(12);
        chk_empty("t6_ped");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
